fc_ctrl: RTL and testbench

FC_CTRL -- requirements
Module: fc_ctrl

---
 rtl/fc_ctrl.sv | 143 ++++++++++++++
 tb/tb_fc_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_ctrl.sv
// Sequencer for a fully connected PE array. Each output tile runs the same
// sequence: load one weight row, stream the input vector, then drain the array.
module fc_ctrl #(
  parameter int FC_SIZE = 8,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] in_len_i,
  input  logic [LEN_W-1:0] num_tiles_i,
  output logic             w_rd_en_o,
  output logic [LEN_W-1:0] w_rd_addr_o,
  output logic             pe_load_o,
  output logic             x_rd_en_o,
  output logic [LEN_W-1:0] x_rd_addr_o,
  output logic             ifmap_valid_o,
  output logic             psum_valid_o,
  output logic [LEN_W-1:0] psum_tile_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int DW = $clog2(FC_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    WREAD,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_inLen;
  logic [LEN_W-1:0] r_numTiles;
  logic [LEN_W-1:0] r_tile;
  logic [LEN_W-1:0] r_xCnt;
  logic [DW-1:0]    r_drainCnt;
  logic             r_ifmapValid;
  logic             w_startOk;
  logic             w_lastX;
  logic             w_lastDrain;
  logic             w_lastTile;

  assign w_startOk   = start_i && (in_len_i != '0) && (num_tiles_i != '0);
  assign w_lastX     = (r_xCnt == r_inLen - LEN_W'(1));
  assign w_lastDrain = (r_drainCnt == DW'(FC_SIZE));
  assign w_lastTile  = (r_tile == r_numTiles - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort takes priority everywhere, including over a start request in IDLE.
  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start_i) w_next = w_startOk ? WREAD : DONE;
        WREAD:   w_next = WLOAD;
        WLOAD:   w_next = STREAM;
        STREAM:  if (w_lastX) w_next = DRAIN;
        DRAIN:   if (w_lastDrain) w_next = w_lastTile ? DONE : WREAD;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Counters only move on the edge that also raises their strobe, so the
  // address outputs hold their last strobed value whenever the strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inLen      <= '0;
      r_numTiles   <= '0;
      r_tile       <= '0;
      r_xCnt       <= '0;
      r_drainCnt   <= '0;
      r_ifmapValid <= 1'b0;
    end else begin
      r_ifmapValid <= x_rd_en_o;
      if (!abort_i) begin
        case (r_state)
          IDLE: begin
            if (w_startOk) begin
              r_inLen    <= in_len_i;
              r_numTiles <= num_tiles_i;
              r_tile     <= '0;
            end
          end
          WLOAD: begin
            r_xCnt <= '0;
          end
          STREAM: begin
            r_drainCnt <= '0;
            if (!w_lastX) r_xCnt <= r_xCnt + LEN_W'(1);
          end
          DRAIN: begin
            r_drainCnt <= r_drainCnt + DW'(1);
            if (w_lastDrain && !w_lastTile) r_tile <= r_tile + LEN_W'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Completion pulses are suppressed in a cycle that is being aborted.
  always_comb begin
    w_rd_en_o    = 1'b0;
    pe_load_o    = 1'b0;
    x_rd_en_o    = 1'b0;
    psum_valid_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (r_state != IDLE);
    case (r_state)
      WREAD:   w_rd_en_o = 1'b1;
      WLOAD:   pe_load_o = 1'b1;
      STREAM:  x_rd_en_o = 1'b1;
      DRAIN:   psum_valid_o = w_lastDrain && !abort_i;
      DONE:    done_o = !abort_i;
      default: begin
      end
    endcase
  end

  assign w_rd_addr_o   = r_tile;
  assign x_rd_addr_o   = r_xCnt;
  assign psum_tile_o   = r_tile;
  assign ifmap_valid_o = r_ifmapValid;

endmodule

// File: tb/tb_fc_ctrl.sv
// Self-checking bench for fc_ctrl: every job is compared cycle by cycle
// against a timeline computed arithmetically from tile period and lengths.
module tb_fc_ctrl;

  localparam int FC = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic [LW-1:0] in_len_i;
  logic [LW-1:0] num_tiles_i;
  logic          w_rd_en_o;
  logic [LW-1:0] w_rd_addr_o;
  logic          pe_load_o;
  logic          x_rd_en_o;
  logic [LW-1:0] x_rd_addr_o;
  logic          ifmap_valid_o;
  logic          psum_valid_o;
  logic [LW-1:0] psum_tile_o;
  logic          busy_o;
  logic          done_o;

  int            errors = 0;
  int            checks = 0;
  logic [LW-1:0] expW = '0;
  logic [LW-1:0] expX = '0;
  logic          prevDone = 1'b0;
  logic          prevPsum = 1'b0;
  logic [3*LW+7:0] allOut;

  typedef struct {
    bit busy;
    bit done;
    bit wEn;
    bit pe;
    bit xEn;
    bit psum;
    int tile;
    int xAddr;
  } exp_t;

  always #5 clk = ~clk;

  assign allOut = {w_rd_en_o, w_rd_addr_o, pe_load_o, x_rd_en_o, x_rd_addr_o,
                   ifmap_valid_o, psum_valid_o, psum_tile_o, busy_o, done_o};

  fc_ctrl #(.FC_SIZE(FC), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .in_len_i(in_len_i), .num_tiles_i(num_tiles_i),
    .w_rd_en_o(w_rd_en_o), .w_rd_addr_o(w_rd_addr_o), .pe_load_o(pe_load_o),
    .x_rd_en_o(x_rd_en_o), .x_rd_addr_o(x_rd_addr_o), .ifmap_valid_o(ifmap_valid_o),
    .psum_valid_o(psum_valid_o), .psum_tile_o(psum_tile_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Cycle (relative to the start cycle 0) at which done_o is due.
  function automatic int jobEnd(input int L, input int T);
    if (L == 0 || T == 0) return 1;
    return T * (L + FC + 3) + 1;
  endfunction

  function automatic exp_t model(input int L, input int T, input int abortAt, input int k);
    exp_t e;
    int per, r, last;
    e = '{default: 0};
    last = jobEnd(L, T);
    if (k < 1 || k > last) return e;
    if (abortAt > 0 && k > abortAt) return e;
    e.busy = 1;
    if (k == last) begin
      e.done = (k != abortAt);
      return e;
    end
    per     = L + FC + 3;
    r       = (k - 1) % per;
    e.tile  = (k - 1) / per;
    e.wEn   = (r == 0);
    e.pe    = (r == 1);
    e.xEn   = (r >= 2) && (r < L + 2);
    e.xAddr = r - 2;
    e.psum  = (r == per - 1) && (k != abortAt);
    return e;
  endfunction

  // Structural properties that must hold in every cycle out of reset.
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1) begin
      checks++;
      if ((int'(w_rd_en_o) + int'(pe_load_o) + int'(x_rd_en_o)) > 1) begin
        errors++;
        $display("[TB] FAIL strobe_excl t=%0t got w=%b pe=%b x=%b exp at most one", $time, w_rd_en_o, pe_load_o, x_rd_en_o);
      end
      checks++;
      if ((done_o && prevDone) || (psum_valid_o && prevPsum)) begin
        errors++;
        $display("[TB] FAIL pulse_width t=%0t got done=%b/%b psum=%b/%b exp single-cycle", $time, prevDone, done_o, prevPsum, psum_valid_o);
      end
    end
    prevDone = done_o;
    prevPsum = psum_valid_o;
  end

  task automatic run_job(input int L, input int T, input int abortAt, input string tag);
    exp_t e, ep;
    int last, stop;
    last = jobEnd(L, T);
    stop = (abortAt > 0) ? abortAt + 2 : last + 2;
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b0;
    in_len_i = LW'(L);
    num_tiles_i = LW'(T);
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      if (k <= last && (abortAt == 0 || k < abortAt)) begin
        start_i = 1'($urandom_range(0, 1));
        in_len_i = LW'($urandom);
        num_tiles_i = LW'($urandom);
      end else begin
        start_i = 1'b0;
      end
      abort_i = (k == abortAt);
      #1;
      e  = model(L, T, abortAt, k);
      ep = model(L, T, abortAt, k - 1);
      if (e.wEn) expW = LW'(e.tile);
      if (e.xEn) expX = LW'(e.xAddr);
      checks += 9;
      if (busy_o !== e.busy)        begin errors++; $display("[TB] FAIL %s busy cyc=%0d got=%b exp=%b", tag, k, busy_o, e.busy); end
      if (done_o !== e.done)        begin errors++; $display("[TB] FAIL %s done cyc=%0d got=%b exp=%b", tag, k, done_o, e.done); end
      if (w_rd_en_o !== e.wEn)      begin errors++; $display("[TB] FAIL %s w_rd_en cyc=%0d got=%b exp=%b", tag, k, w_rd_en_o, e.wEn); end
      if (pe_load_o !== e.pe)       begin errors++; $display("[TB] FAIL %s pe_load cyc=%0d got=%b exp=%b", tag, k, pe_load_o, e.pe); end
      if (x_rd_en_o !== e.xEn)      begin errors++; $display("[TB] FAIL %s x_rd_en cyc=%0d got=%b exp=%b", tag, k, x_rd_en_o, e.xEn); end
      if (ifmap_valid_o !== ep.xEn) begin errors++; $display("[TB] FAIL %s ifmap_valid cyc=%0d got=%b exp=%b", tag, k, ifmap_valid_o, ep.xEn); end
      if (psum_valid_o !== e.psum)  begin errors++; $display("[TB] FAIL %s psum_valid cyc=%0d got=%b exp=%b", tag, k, psum_valid_o, e.psum); end
      if (w_rd_addr_o !== expW)     begin errors++; $display("[TB] FAIL %s w_rd_addr cyc=%0d got=%0d exp=%0d", tag, k, w_rd_addr_o, expW); end
      if (x_rd_addr_o !== expX)     begin errors++; $display("[TB] FAIL %s x_rd_addr cyc=%0d got=%0d exp=%0d", tag, k, x_rd_addr_o, expX); end
      if (e.psum) begin
        checks++;
        if (psum_tile_o !== LW'(e.tile)) begin errors++; $display("[TB] FAIL %s psum_tile cyc=%0d got=%0d exp=%0d", tag, k, psum_tile_o, e.tile); end
      end
      if (k == last && abortAt == 0 && L != 0 && T != 0) begin
        checks++;
        if (dut.r_inLen !== LW'(L) || dut.r_numTiles !== LW'(T)) begin
          errors++;
          $display("[TB] FAIL %s latched_len got=%0d/%0d exp=%0d/%0d", tag, dut.r_inLen, dut.r_numTiles, L, T);
        end
      end
    end
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    in_len_i = '0;
    num_tiles_i = '0;
    #6;
    checks++;
    if (allOut !== '0) begin errors++; $display("[TB] FAIL reset_outputs got=%h exp=0", allOut); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_tile();
    run_job(4, 1, 0, "single");
  endtask

  task automatic test_multi_tile();
    run_job(2, 3, 0, "multi");
  endtask

  task automatic test_zero_len();
    run_job(0, 3, 0, "zero_len");
    run_job(5, 0, 0, "zero_tiles");
  endtask

  task automatic test_abort();
    run_job(2, 3, 16, "abort_stream");
    run_job(1, 2, 12, "abort_lastdrain");
  endtask

  task automatic test_back_to_back();
    run_job(2, 3, 0, "after_abort");
    run_job(1, 1, 0, "b2b");
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    in_len_i = 8'd2;
    num_tiles_i = 8'd1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (busy_o !== 1'b0 || w_rd_en_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_start_idle cyc=%0d got busy=%b w=%b done=%b exp all 0", k, busy_o, w_rd_en_o, done_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    start_i = 1'b1;
    in_len_i = 8'd3;
    num_tiles_i = 8'd1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #1;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy got=%b exp=1", busy_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (allOut !== '0) begin errors++; $display("[TB] FAIL async_reset got=%h exp=0", allOut); end
    checks++;
    if (dut.r_inLen !== '0 || dut.r_numTiles !== '0) begin
      errors++;
      $display("[TB] FAIL reset_latched got=%0d/%0d exp=0/0", dut.r_inLen, dut.r_numTiles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expW = '0;
    expX = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle cyc=%0d got busy=%b done=%b exp 0", k, busy_o, done_o);
      end
    end
    run_job(3, 2, 0, "after_reset");
  endtask

  task automatic test_boundary();
    run_job(1, 1, 0, "len1");
    run_job(255, 2, 0, "len_max");
    run_job(1, 255, 0, "tiles_max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_job($urandom_range(0, 6), $urandom_range(0, 3), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_abort_start_idle();
    test_reset_mid_drain();
    test_boundary();
    test_random();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
